// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one completed functional-unit result per cycle
// (round-robin or fixed priority) and drives it as a registered CDB broadcast.
module cdb_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_IX_WIDTH = 3,
  parameter int MODE         = 0,
  parameter int SRC_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_CH-1:0]              fu_valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   fu_data_in,
  input  logic [NUM_CH*ROB_IX_WIDTH-1:0] fu_rob_ix_in,
  input  logic                           flush_in,
  output logic [NUM_CH-1:0]              fu_read_out,
  output logic                           cdb_valid_out,
  output logic [DATA_WIDTH-1:0]          cdb_value_out,
  output logic [ROB_IX_WIDTH-1:0]        cdb_rob_ix_out,
  output logic [SRC_W-1:0]               cdb_src_out,
  output logic [31:0]                    bcast_count_out
);

  logic [DATA_WIDTH-1:0]   data_ch   [NUM_CH];
  logic [ROB_IX_WIDTH-1:0] rob_ix_ch [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign data_ch[k]   = fu_data_in[k*DATA_WIDTH +: DATA_WIDTH];
    assign rob_ix_ch[k] = fu_rob_ix_in[k*ROB_IX_WIDTH +: ROB_IX_WIDTH];
  end

  logic [SRC_W-1:0]        rr_ptr;
  logic [NUM_CH-1:0]       read_q;
  logic                    cdb_valid;
  logic [DATA_WIDTH-1:0]   cdb_value;
  logic [ROB_IX_WIDTH-1:0] cdb_rob_ix;
  logic [SRC_W-1:0]        cdb_src;
  logic [31:0]             bcast_count;

  logic [NUM_CH-1:0]       req;
  logic                    grant_valid;
  logic [SRC_W-1:0]        grant_ix;
  logic [SRC_W-1:0]        cand;
  logic [SRC_W-1:0]        next_ptr;

  // A channel acknowledged this cycle still shows valid; mask it so it is not
  // broadcast twice.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value undefined and no latch is inferred.
  always_comb begin
    req         = fu_valid_in & ~read_q;
    grant_valid = 1'b0;
    grant_ix    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (MODE == 0) begin
        cand = ((int'(rr_ptr) + i) >= NUM_CH) ? SRC_W'(int'(rr_ptr) + i - NUM_CH)
                                              : SRC_W'(int'(rr_ptr) + i);
      end else begin
        cand = SRC_W'(i);
      end
      if (!grant_valid && !flush_in && req[cand]) begin
        grant_valid = 1'b1;
        grant_ix    = cand;
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (int'(grant_ix) != NUM_CH - 1) begin
      next_ptr = grant_ix + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr      <= '0;
      read_q      <= '0;
      cdb_valid   <= 1'b0;
      cdb_value   <= '0;
      cdb_rob_ix  <= '0;
      cdb_src     <= '0;
      bcast_count <= '0;
    end else begin
      if (grant_valid) begin
        cdb_valid   <= 1'b1;
        cdb_value   <= data_ch[grant_ix];
        cdb_rob_ix  <= rob_ix_ch[grant_ix];
        cdb_src     <= grant_ix;
        read_q      <= {{(NUM_CH-1){1'b0}}, 1'b1} << grant_ix;
        bcast_count <= bcast_count + 32'd1;
        if (MODE == 0) begin
          rr_ptr <= next_ptr;
        end
      end else begin
        cdb_valid <= 1'b0;
        read_q    <= '0;
      end
      if (flush_in) begin
        rr_ptr <= '0;
      end
    end
  end

  assign fu_read_out     = read_q;
  assign cdb_valid_out   = cdb_valid;
  assign cdb_value_out   = cdb_value;
  assign cdb_rob_ix_out  = cdb_rob_ix;
  assign cdb_src_out     = cdb_src;
  assign bcast_count_out = bcast_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a round-robin and a fixed-priority instance share the
// same stimulus and are compared against a behavioural model of the grant rules.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  fu_valid = '0;
  logic [N*DW-1:0] fu_data = '0;
  logic [N*RW-1:0] fu_rob = '0;

  logic [N-1:0]  rd   [2];
  logic          cv   [2];
  logic [DW-1:0] val  [2];
  logic [RW-1:0] rob  [2];
  logic [SW-1:0] src  [2];
  logic [31:0]   cnt  [2];

  int checks = 0;
  int failures = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance
  int            m_ptr   [2];
  logic [N-1:0]  m_read  [2];
  logic          m_valid [2];
  logic [DW-1:0] m_value [2];
  logic [RW-1:0] m_rob   [2];
  logic [SW-1:0] m_src   [2];
  logic [31:0]   m_cnt   [2];

  cdb_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ROB_IX_WIDTH(RW), .MODE(0)) dut_rr (
    .clk_in(clk), .rst_in(rst), .fu_valid_in(fu_valid), .fu_data_in(fu_data),
    .fu_rob_ix_in(fu_rob), .flush_in(flush), .fu_read_out(rd[0]),
    .cdb_valid_out(cv[0]), .cdb_value_out(val[0]), .cdb_rob_ix_out(rob[0]),
    .cdb_src_out(src[0]), .bcast_count_out(cnt[0])
  );

  cdb_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ROB_IX_WIDTH(RW), .MODE(1)) dut_fp (
    .clk_in(clk), .rst_in(rst), .fu_valid_in(fu_valid), .fu_data_in(fu_data),
    .fu_rob_ix_in(fu_rob), .flush_in(flush), .fu_read_out(rd[1]),
    .cdb_valid_out(cv[1]), .cdb_value_out(val[1]), .cdb_rob_ix_out(rob[1]),
    .cdb_src_out(src[1]), .bcast_count_out(cnt[1])
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // First requesting channel found when scanning upward from start, wrapping.
  function automatic int pick(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (start + i) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_read[m] = '0; m_valid[m] = 1'b0; m_value[m] = '0;
      m_rob[m] = '0; m_src[m] = '0; m_cnt[m] = '0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] req;
      int g;
      req = fu_valid & ~m_read[m];
      g = flush ? -1 : pick(req, (m == 0) ? m_ptr[m] : 0);
      if (g >= 0) begin
        m_valid[m] = 1'b1;
        m_value[m] = fu_data[g*DW +: DW];
        m_rob[m]   = fu_rob[g*RW +: RW];
        m_src[m]   = SW'(g);
        m_read[m]  = N'(1) << g;
        m_cnt[m]   = m_cnt[m] + 32'd1;
        if (m == 0) m_ptr[m] = (g + 1) % N;
      end else begin
        m_valid[m] = 1'b0;
        m_read[m]  = '0;
      end
      if (flush) m_ptr[m] = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (cv[m] !== 1'b0 || rd[m] !== '0 || src[m] !== '0 || cnt[m] !== '0 ||
          val[m] !== '0 || rob[m] !== '0) begin
        failures++;
        $display("FAIL reset dut%0d: valid=%b read=%b src=%0d count=%0d value=%h rob=%0d, required all zero",
                 m, cv[m], rd[m], src[m], cnt[m], val[m], rob[m]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    fu_valid = 4'b0010;
    fu_data[1*DW +: DW] = 32'h1234_5678;
    fu_rob[1*RW +: RW]  = 3'd5;
    tick();
    checks++;
    if (cv[0] !== 1'b1 || val[0] !== 32'h1234_5678 || rob[0] !== 3'd5 ||
        src[0] !== 2'd1 || rd[0] !== 4'b0010 || cnt[0] !== 32'd1) begin
      failures++;
      $display("FAIL single_grant: valid=%b value=%h rob=%0d src=%0d read=%b count=%0d, required 1 12345678 5 1 0010 1",
               cv[0], val[0], rob[0], src[0], rd[0], cnt[0]);
    end
    @(negedge clk);
    tick();
    checks++;
    if (cv[0] !== 1'b0 || rd[0] !== 4'b0000 || cnt[0] !== 32'd1) begin
      failures++;
      $display("FAIL single_no_double: valid=%b read=%b count=%0d, required 0 0000 1",
               cv[0], rd[0], cnt[0]);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    fu_valid = 4'b1111;
    fu_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    checks++;
    if (cv[0] !== 1'b1 || src[0] !== 2'd2 || cnt[0] !== 32'd2) begin
      failures++;
      $display("FAIL flush_pre_grant: valid=%b src=%0d count=%0d, required 1 2 2", cv[0], src[0], cnt[0]);
    end
    @(negedge clk);
    flush = 1'b1;
    tick();
    checks++;
    if (cv[0] !== 1'b0 || rd[0] !== 4'b0000 || cnt[0] !== 32'd2 ||
        cv[1] !== 1'b0 || rd[1] !== 4'b0000 || cnt[1] !== 32'd2) begin
      failures++;
      $display("FAIL flush_suppress: rr valid=%b read=%b count=%0d fp valid=%b read=%b count=%0d, required 0 0000 2 / 0 0000 2",
               cv[0], rd[0], cnt[0], cv[1], rd[1], cnt[1]);
    end
    @(negedge clk);
    flush = 1'b0;
    tick();
    checks++;
    if (cv[0] !== 1'b1 || src[0] !== 2'd0 || cnt[0] !== 32'd3) begin
      failures++;
      $display("FAIL flush_restart: valid=%b src=%0d count=%0d, required 1 0 3", cv[0], src[0], cnt[0]);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] exp_v;
      int exp_src;
      @(negedge clk);
      fu_valid = 4'b1111;
      fu_data  = {$urandom, $urandom, $urandom, $urandom};
      exp_src  = (i + 1) % N;
      exp_v    = fu_data[exp_src*DW +: DW];
      tick();
      checks++;
      if (cv[0] !== 1'b1 || src[0] !== SW'(exp_src) || val[0] !== exp_v) begin
        failures++;
        $display("FAIL round_robin step %0d: valid=%b src=%0d value=%h, required 1 %0d %h",
                 i, cv[0], src[0], val[0], exp_src, exp_v);
      end
    end
  endtask

  task automatic test_fixed_priority();
    int exp_seq [3] = '{0, 2, 0};
    @(negedge clk);
    fu_valid = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fu_valid = 4'b0101;
      tick();
      checks++;
      if (cv[1] !== 1'b1 || src[1] !== SW'(exp_seq[i])) begin
        failures++;
        $display("FAIL fixed_priority step %0d: valid=%b src=%0d, required 1 %0d",
                 i, cv[1], src[1], exp_seq[i]);
      end
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    fu_valid = 4'b0000;
    tick();
    @(negedge clk);
    force dut_rr.bcast_count = 32'hFFFF_FFFF;
    force dut_fp.bcast_count = 32'hFFFF_FFFF;
    #1;
    release dut_rr.bcast_count;
    release dut_fp.bcast_count;
    m_cnt[0] = 32'hFFFF_FFFF;
    m_cnt[1] = 32'hFFFF_FFFF;
    fu_valid = 4'b0001;
    tick();
    checks++;
    if (cnt[0] !== 32'd0 || cnt[1] !== 32'd0 || cv[0] !== 1'b1 || cv[1] !== 1'b1) begin
      failures++;
      $display("FAIL counter_wrap: rr count=%h valid=%b fp count=%h valid=%b, required 0 1 0 1",
               cnt[0], cv[0], cnt[1], cv[1]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    fu_valid = 4'b0100;
    tick();
    checks++;
    if (cv[0] !== 1'b1 || src[0] !== 2'd2) begin
      failures++;
      $display("FAIL reset_mid_setup: valid=%b src=%0d, required 1 2", cv[0], src[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cv[0] !== 1'b0 || rd[0] !== '0 || src[0] !== '0 || cnt[0] !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: valid=%b read=%b src=%0d count=%0d, required all zero",
               cv[0], rd[0], src[0], cnt[0]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (cv[0] !== 1'b1 || src[0] !== 2'd2 || cnt[0] !== 32'd1) begin
      failures++;
      $display("FAIL reset_rearbitrate: valid=%b src=%0d count=%0d, required 1 2 1", cv[0], src[0], cnt[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      fu_valid = N'($urandom);
      fu_data  = {$urandom, $urandom, $urandom, $urandom};
      fu_rob   = N*RW'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (cv[m] !== m_valid[m] || rd[m] !== m_read[m] || cnt[m] !== m_cnt[m] ||
            val[m] !== m_value[m] || rob[m] !== m_rob[m] || src[m] !== m_src[m]) begin
          failures++;
          $display("FAIL random dut%0d cycle %0d: valid=%b read=%b count=%0d value=%h rob=%0d src=%0d, required %b %b %0d %h %0d %0d",
                   m, c, cv[m], rd[m], cnt[m], val[m], rob[m], src[m],
                   m_valid[m], m_read[m], m_cnt[m], m_value[m], m_rob[m], m_src[m]);
        end
      end
    end
    @(negedge clk);
    flush = 1'b0;
    fu_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_flush();
    test_round_robin();
    test_fixed_priority();
    test_counter_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
